// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling down-counter FSM,
// single-entry output register with valid/ready handshake, frame-error pulse and sticky overrun.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for rxs=0
  // START     | counting to the middle of the start bit
  // DATA      | sampling data bits 0..7, one per bit time
  // STOP      | counting to the middle of the stop bit
  // WAIT_HIGH | framing error seen, waiting for the break to end
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rx_meta_q, rxs_q;
  logic          complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
            cnt_d     = BIT_M1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d[bit_idx_q] = rxs_q;
          cnt_d              = BIT_M1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            state_d  = IDLE;
            complete = 1'b1;
          end else begin
            state_d     = WAIT_HIGH;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A completed byte only overwrites the holding register if it is free or being read this cycle.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (complete) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: table of clean frames plus
// hand-written glitch, break, overrun and mid-frame reset sequences.
module tb_uart_receiver;

  localparam int C = 16;
  // rxd->rxs synchronizer (2) + C/2 + 9*C + 1
  localparam int LAT = 2 + C / 2 + 9 * C + 1;

  logic       clk, rst, rxd, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         vcnt = 0, ferr_cnt = 0, rise_cyc = -1;
  logic [7:0] cap_data = 8'h00;
  logic       valid_last = 1'b0;
  always @(negedge clk) begin
    if (valid) vcnt = vcnt + 1;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (valid && !valid_last) begin
      rise_cyc = cyc;
      cap_data = data;
    end
    valid_last = valid;
  end

  int tests = 0, fails = 0;
  int start_cyc, v0, f0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_time(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b);
    start_cyc = cyc;
    v0 = vcnt;
    f0 = ferr_cnt;
    bit_time(1'b0, C);
    for (int i = 0; i < 8; i++) bit_time(b[i], C);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b);
    bit_time(1'b1, C);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    int         exp_vcyc;
    int         exp_lat;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 1, LAT};
    vecs[1] = '{8'h00, 8'h00, 1, LAT};
    vecs[2] = '{8'hFF, 8'hFF, 1, LAT};
    vecs[3] = '{8'h5A, 8'h5A, 1, LAT};
    vecs[4] = '{8'h81, 8'h81, 1, LAT};
    vecs[5] = '{8'h01, 8'h01, 1, LAT};
    vecs[6] = '{8'h80, 8'h80, 1, LAT};

    rst = 1'b1; rxd = 1'b1; ready = 1'b1;
    #2;
    check("rst data", int'(data), 8'h00);
    check("rst valid", int'(valid), 0);
    check("rst frame_err", int'(frame_err), 0);
    check("rst overrun", int'(overrun), 0);
    check("rst busy", int'(busy), 0);
    #20 rst = 1'b0;
    @(posedge clk); #1;
    bit_time(1'b1, 4);

    // clean back-to-back frames, ready held high
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].din);
      check($sformatf("vec%0d data", i), int'(cap_data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d valid cycles", i), vcnt - v0, vecs[i].exp_vcyc);
      check($sformatf("vec%0d latency", i), rise_cyc - start_cyc, vecs[i].exp_lat);
      check($sformatf("vec%0d frame_err", i), ferr_cnt - f0, 0);
      check($sformatf("vec%0d overrun", i), int'(overrun), 0);
    end

    // 5-cycle glitch is rejected at the start sample
    v0 = vcnt; f0 = ferr_cnt;
    bit_time(1'b0, 5);
    bit_time(1'b1, 3);
    check("glitch busy during", int'(busy), 1);
    bit_time(1'b1, 30);
    check("glitch busy after", int'(busy), 0);
    check("glitch valid", vcnt - v0, 0);
    check("glitch frame_err", ferr_cnt - f0, 0);

    // framing error followed by a 40-bit break, then a clean frame
    send_bits(8'h3C);
    bit_time(1'b0, 40 * C);
    check("break frame_err pulses", ferr_cnt - f0, 1);
    check("break valid", vcnt - v0, 0);
    check("break busy", int'(busy), 1);
    bit_time(1'b1, C);
    check("break busy released", int'(busy), 0);
    send_frame(8'h81);
    check("post-break data", int'(cap_data), 8'h81);
    check("post-break latency", rise_cyc - start_cyc, LAT);

    // overrun: consumer stalled across two frames
    ready = 1'b0;
    send_frame(8'h11);
    send_frame(8'h22);
    check("ovr data", int'(data), 8'h11);
    check("ovr valid", int'(valid), 1);
    check("ovr overrun", int'(overrun), 1);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check("ovr read valid", int'(valid), 0);
    check("ovr read overrun", int'(overrun), 0);
    bit_time(1'b1, 3);
    check("ready idle no effect", int'(valid), 0);

    // ready coincides with the second completion: byte replaces, no overrun
    send_frame(8'h11);
    fork
      send_frame(8'h22);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    check("swap data", int'(data), 8'h22);
    check("swap valid", int'(valid), 1);
    check("swap overrun", int'(overrun), 0);

    // async reset between edges during data bit 4; remaining bits are all 1
    fork
      send_frame(8'hF0);
      begin
        repeat (90) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst data", int'(data), 8'h00);
        check("midrst valid", int'(valid), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst frame_err", int'(frame_err), 0);
        check("midrst overrun", int'(overrun), 0);
        #1 rst = 1'b0;
      end
    join
    check("midrst no spurious byte", int'(valid), 0);
    ready = 1'b1;
    send_frame(8'h5A);
    check("post-rst data", int'(cap_data), 8'h5A);
    check("post-rst latency", rise_cyc - start_cyc, LAT);
    check("post-rst valid cycles", vcnt - v0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, system clocks per bit (100 MHz / 9600 baud); legal range 4 or more.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rxd, input, 1, asynchronous serial line; idles high; 8N1 frames, LSB first.
REQ-005 SHALL have port data, output, 8, received byte; valid only while valid=1.
REQ-006 SHALL have port valid, output, 1, data holds an unread byte.
REQ-007 SHALL have port ready, input, 1, consumer accepts data on a cycle where valid=1 and ready=1.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port overrun, output, 1, sticky flag: a completed byte was dropped.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; both flops reset to 1; all further logic uses the second flop (rxs).
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a down-counter of width ceil(log2(CLKS_PER_BIT)) or more.
REQ-013 IDLE: rxs=0 -> START, counter loaded so that the start sample falls floor(CLKS_PER_BIT/2) cycles after the first cycle rxs=0 is seen.
REQ-014 START sample: rxs=1 -> IDLE, glitch rejected, no flags; rxs=0 -> DATA, bit index 0.
REQ-015 DATA: samples exactly CLKS_PER_BIT cycles apart; sample k (k=0..7) stored to shift-register bit k; after bit 7 -> STOP.
REQ-016 STOP sample, CLKS_PER_BIT after bit 7: rxs=1 -> byte complete, IDLE; rxs=0 -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL stay until rxs=1, then -> IDLE; no start is detected during a break.
REQ-018 Byte complete with valid=0, or with valid=1 and ready=1 in the same cycle: data loaded, valid=1 on the next cycle, overrun unchanged.
REQ-019 Byte complete with valid=1 and ready=0: new byte dropped, data unchanged, overrun set to 1 on the next cycle.
REQ-020 valid=1 and ready=1 with no completion: valid cleared next cycle; overrun cleared on the same edge.
REQ-021 ready while valid=0 SHALL have no effect.
REQ-022 Latency: valid rises floor(CLKS_PER_BIT/2) + 9*CLKS_PER_BIT + 1 cycles after the first rxs=0 cycle.
REQ-023 A new start bit SHALL be accepted on the cycle after the stop sample returns to IDLE; back-to-back frames lose no byte.

Reset
REQ-024 rst=1 SHALL force immediately, clock-independent: state IDLE, counter 0, shift register 0, data=8'h00, valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-025 Reset mid-frame SHALL discard the partial byte; after release, the remaining line activity is parsed from IDLE.

Verification (CLKS_PER_BIT=16)
REQ-026 Frame 8'hA5, ready=1 -> valid high for exactly 1 cycle, data=8'hA5, 153 cycles after first rxs=0; frame_err=0; overrun=0.
REQ-027 Low pulse of 5 cycles on idle line -> returns to IDLE after the start sample; valid, frame_err and busy end at 0.
REQ-028 Frame 8'h3C with stop bit held low for 40 bit times -> frame_err single pulse, valid=0, busy=1 until line high; next frame 8'h81 -> data=8'h81.
REQ-029 ready=0, frames 8'h11 then 8'h22 back-to-back -> data=8'h11, valid=1, overrun=1; ready pulse -> valid=0, overrun=0.
REQ-030 ready=1 held on the cycle of the second completion -> data=8'h22 loaded, overrun stays 0.
REQ-031 rst pulse asserted between clock edges during data bit 4 -> all outputs at reset values before the next edge; a following clean frame 8'h5A is received correctly.
